regfile_wb_arbiter: RTL and testbench

//  Write-back arbiter and scoreboard for the 32x32 register file (single write port).

---
 rtl/regfile_wb_arbiter.sv | 121 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: write-back arbiter and RAW/WAW scoreboard for the register file.
// The ALU and LSU result paths share the single register-file write port through valid/ready
// handshakes. The winning result is registered onto RegWrite/rd_addr/rd_data one cycle after
// the handshake. A busy bit per register tracks pending writes so issue logic can stall.
// Build option: define RR_ARB_EN for round-robin arbitration on conflict.
// Without it, fixed priority applies and the LSU wins every conflict.
module regfile_wb_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rd_busy,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int NREG = 1 << ADDR_W;

  logic              alu_grant;
  logic              lsu_grant;
  logic              win_write;
  logic [ADDR_W-1:0] win_rd;
  logic [DATA_W-1:0] win_data;
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_next;

`ifdef RR_ARB_EN
  // Pointer: 1 means the ALU is preferred at the next conflict.
  logic alu_next;

  // Grant the lone requester, or on conflict the one the pointer prefers.
  always_comb begin
    alu_grant = 1'b0;
    lsu_grant = 1'b0;
    if (alu_valid && lsu_valid) begin
      if (alu_next) alu_grant = 1'b1;
      else          lsu_grant = 1'b1;
    end else begin
      alu_grant = alu_valid;
      lsu_grant = lsu_valid;
    end
  end

  // Flip preference away from whoever completed a transfer, so a loser always goes next.
  always_ff @(posedge clk) begin
    if (!rst_n)         alu_next <= 1'b1;
    else if (alu_grant) alu_next <= 1'b0;
    else if (lsu_grant) alu_next <= 1'b1;
  end
`else
  // Fixed priority: the LSU always wins. A load result frees an LSU slot sooner.
  always_comb begin
    lsu_grant = lsu_valid;
    alu_grant = alu_valid & ~lsu_valid;
  end
`endif

  assign alu_ready = alu_grant;
  assign lsu_ready = lsu_grant;

  // Mux the winner onto the write path. Writes to x0 complete the handshake but never reach the port.
  always_comb begin
    win_rd    = alu_rd;
    win_data  = alu_data;
    if (lsu_grant) begin
      win_rd   = lsu_rd;
      win_data = lsu_data;
    end
    win_write = (alu_grant | lsu_grant) && (win_rd != '0);
  end

  // Register the write port. Address and data are held while no write is in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      RegWrite <= 1'b0;
      rd_addr  <= '0;
      rd_data  <= '0;
    end else begin
      RegWrite <= win_write;
      if (win_write) begin
        rd_addr <= win_rd;
        rd_data <= win_data;
      end
    end
  end

  // Scoreboard next state: clear on the write the register file is capturing; a same-edge issue wins.
  always_comb begin
    busy_next = busy;
    if (RegWrite) busy_next[rd_addr] = 1'b0;
    if (iss_valid && (iss_rd != '0)) busy_next[iss_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

  assign rs1_busy = busy[rs1_addr];
  assign rs2_busy = busy[rs2_addr];
  assign rd_busy  = busy[iss_rd];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios followed by random traffic.
// A transaction-level reference model predicts grants, the write port and the busy set.
// It follows the RR_ARB_EN build option in the same way as the design.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, lsu_valid, iss_valid;
  logic        alu_ready, lsu_ready;
  logic [4:0]  alu_rd, lsu_rd, iss_rd, rs1_addr, rs2_addr;
  logic [31:0] alu_data, lsu_data;
  logic        rs1_busy, rs2_busy, rd_busy;
  logic        RegWrite;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit [31:0]   m_busy;
  bit          m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_alu_next;
  bit          last_alu_g, last_lsu_g;
  logic [4:0]  wlog[$];

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
    .RegWrite(RegWrite), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                               input bit lv, input logic [4:0] lrd, input logic [31:0] ld,
                               input bit iv, input logic [4:0] ird);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    iss_valid = iv; iss_rd = ird;
  endtask

  task automatic modelReset();
    m_busy = '0; m_we = 1'b0; m_addr = '0; m_data = '0; m_alu_next = 1'b1;
  endtask

  // Called just after a posedge with inputs applied; checks before the next edge, then advances the model.
  task automatic runCycle();
    bit eg_alu, eg_lsu;
    logic [4:0]  wrd;
    logic [31:0] wdat;
`ifdef RR_ARB_EN
    eg_lsu = lsu_valid && (!alu_valid || !m_alu_next);
`else
    eg_lsu = lsu_valid;
`endif
    eg_alu = alu_valid && !eg_lsu;
    #3;
    checkOutput("alu_ready", alu_ready, eg_alu);
    checkOutput("lsu_ready", lsu_ready, eg_lsu);
    checkOutput("reg_write", RegWrite, m_we);
    if (m_we) begin
      checkOutput("rd_addr", rd_addr, m_addr);
      checkOutput("rd_data", rd_data, m_data);
    end
    checkOutput("rs1_busy", rs1_busy, m_busy[rs1_addr]);
    checkOutput("rs2_busy", rs2_busy, m_busy[rs2_addr]);
    checkOutput("rd_busy", rd_busy, m_busy[iss_rd]);
    if (RegWrite === 1'b1) wlog.push_back(rd_addr);
    last_alu_g = eg_alu;
    last_lsu_g = eg_lsu;
    @(posedge clk);
    if (!rst_n) begin
      modelReset();
    end else begin
      if (m_we) m_busy[m_addr] = 1'b0;
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
      m_we = 1'b0;
      if (eg_alu || eg_lsu) begin
        wrd  = eg_lsu ? lsu_rd : alu_rd;
        wdat = eg_lsu ? lsu_data : alu_data;
        if (wrd != 0) begin
          m_we = 1'b1; m_addr = wrd; m_data = wdat;
        end
        m_alu_next = eg_lsu;
      end
    end
    #1;
  endtask

  logic [4:0] alu_list[2];
  logic [4:0] lsu_list[2];
  logic [4:0] exp_order[4];

  initial begin
    bit          a_pend, l_pend;
    logic [4:0]  a_rd, l_rd;
    logic [31:0] a_dat, l_dat;
    int ai, li;

    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rs1_addr = 0; rs2_addr = 0;
    // Test 1: two reset cycles, then idle
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    rst_n = 1'b1;
    #1;
    checkOutput("rst_reg_write", RegWrite, 0);
    checkOutput("rst_rd_addr", rd_addr, 0);
    checkOutput("rst_rd_data", rd_data, 0);
    checkOutput("rst_alu_ready", alu_ready, 0);
    checkOutput("rst_lsu_ready", lsu_ready, 0);
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      #0.1;
      checkOutput("rst_busy", rs1_busy, 0);
    end
    rs1_addr = 0;
    runCycle();

    // Test 2: single ALU write
    applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    #1;
    checkOutput("t2_alu_ready", alu_ready, 1);
    runCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t2_reg_write", RegWrite, 1);
    checkOutput("t2_rd_addr", rd_addr, 5);
    checkOutput("t2_rd_data", rd_data, 32'hDEADBEEF);
    runCycle();
    checkOutput("t2_reg_write_off", RegWrite, 0);
    wlog.delete();

    // Test 3: both requesters contend for four transfers
    alu_list[0] = 1; alu_list[1] = 2;
    lsu_list[0] = 3; lsu_list[1] = 4;
`ifdef RR_ARB_EN
    exp_order[0] = 3; exp_order[1] = 1; exp_order[2] = 4; exp_order[3] = 2;
`else
    exp_order[0] = 3; exp_order[1] = 4; exp_order[2] = 1; exp_order[3] = 2;
`endif
    ai = 0; li = 0;
    for (int c = 0; c < 10 && (ai < 2 || li < 2); c++) begin
      applyStimulus(ai < 2, alu_list[ai < 2 ? ai : 0], 32'h100 + 32'(ai),
                    li < 2, lsu_list[li < 2 ? li : 0], 32'h200 + 32'(li), 0, 0);
      runCycle();
      if (last_alu_g) ai++;
      if (last_lsu_g) li++;
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    runCycle();
    checkOutput("t3_count", wlog.size(), 4);
    for (int i = 0; i < 4; i++)
      checkOutput("t3_order", (i < wlog.size()) ? wlog[i] : 5'h1f, exp_order[i]);

    // Test 4: issue r7, observe busy through the write cycle
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 7);
    runCycle();
    applyStimulus(1, 7, 32'h7777, 0, 0, 0, 0, 0);
    rs1_addr = 7;
    #1;
    checkOutput("t4_busy_issued", rs1_busy, 1);
    runCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("t4_wr_cycle", RegWrite, 1);
    checkOutput("t4_busy_wr_cycle", rs1_busy, 1);
    runCycle();
    #1;
    checkOutput("t4_busy_cleared", rs1_busy, 0);

    // Test 5: same-edge clear and set of r9, then an x0 write
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 9);
    runCycle();
    applyStimulus(1, 9, 32'h9999, 0, 0, 0, 0, 0);
    runCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 9);
    rs1_addr = 9;
    runCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("t5_busy_set_wins", rs1_busy, 1);
    applyStimulus(1, 0, 32'h1234, 0, 0, 0, 0, 0);
    #1;
    checkOutput("t5_x0_ready", alu_ready, 1);
    runCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t5_x0_no_write", RegWrite, 0);
    runCycle();

    // Test 6: reset during a transfer with r3 busy
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 3);
    runCycle();
    applyStimulus(1, 3, 32'h3333, 0, 0, 0, 0, 0);
    rs1_addr = 3;
    rst_n = 1'b0;
    runCycle();
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("t6_reg_write", RegWrite, 0);
    checkOutput("t6_busy3", rs1_busy, 0);
    runCycle();

    // Random traffic with requesters holding until accepted
    a_pend = 0; l_pend = 0; a_rd = 0; l_rd = 0; a_dat = 0; l_dat = 0;
    for (int c = 0; c < 400; c++) begin
      if (!a_pend && $urandom_range(0, 9) < 6) begin
        a_pend = 1; a_rd = 5'($urandom); a_dat = $urandom;
      end
      if (!l_pend && $urandom_range(0, 9) < 5) begin
        l_pend = 1; l_rd = 5'($urandom); l_dat = $urandom;
      end
      applyStimulus(a_pend, a_rd, a_dat, l_pend, l_rd, l_dat,
                    $urandom_range(0, 9) < 3, 5'($urandom));
      rs1_addr = 5'($urandom);
      rs2_addr = 5'($urandom);
      rst_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      runCycle();
      if (last_alu_g) a_pend = 0;
      if (last_lsu_g) l_pend = 0;
    end
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    runCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
